// File: rtl/hash_request_arbiter.sv
// Round-robin arbiter sharing one hash generator between NUM_REQ requesters; one request in flight at a time.
// Optional feature macro: ARB_TIMEOUT_EN (AWAIT timeout with automatic re-request and sticky error flag).
package hash_request_arbiter_pkg;
    typedef enum logic [1:0] {
        H_GROUND  = 2'd0,
        H_READY   = 2'd1,
        H_HASHING = 2'd2,
        H_OUTPUT  = 2'd3
    } hash_generator_state_t;
endpackage

module hash_request_arbiter
    import hash_request_arbiter_pkg::*;
#(
    parameter int NUM_REQ        = 2,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_W      = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NUM_REQ-1:0]   req_pulse_in,
    input  hash_generator_state_t hash_generator_state,
    output logic                 request_byte_pulse_out,
    input  logic [7:0]           hash_byte,
    input  logic                 hash_byte_pulse,
    output logic [7:0]           hash_byte_out,
    output logic [NUM_REQ-1:0]   hash_byte_pulse_out,
    output logic [NUM_REQ-1:0]   grant_out,
    output logic [NUM_REQ-1:0]   pending_out,
    output logic                 busy_out,
    output logic                 timeout_err_out
);
    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        A_IDLE  = 2'd0,
        A_ISSUE = 2'd1,
        A_AWAIT = 2'd2
    } arb_state_t;

    arb_state_t         r_state;
    logic [NUM_REQ-1:0] r_pending;
    logic [NUM_REQ-1:0] r_grant;
    logic [PTR_W-1:0]   r_grant_idx;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic               r_req_pulse;

    logic [NUM_REQ-1:0] w_pending_next;
    logic [NUM_REQ-1:0] w_sel_onehot;
    logic [PTR_W-1:0]   w_sel_idx;
    logic [PTR_W-1:0]   w_next_ptr;
    logic               w_sel_found;
    logic               w_done;
    logic               w_gen_ready;

    assign w_done      = hash_byte_pulse && (r_state == A_AWAIT);
    assign w_gen_ready = (hash_generator_state == H_GROUND) || (hash_generator_state == H_READY);

    // A new request in the completion cycle outranks the clear, so a back-to-back re-request is never lost.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign w_pending_next[gi]      = req_pulse_in[gi] | (r_pending[gi] & ~(w_done & r_grant[gi]));
            assign hash_byte_pulse_out[gi] = r_grant[gi] & w_done;
        end
    endgenerate

    always_comb begin
        int w_idx;
        w_idx       = 0;
        w_sel_found = 1'b0;
        w_sel_idx   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = (int'(r_rr_ptr) + k) % NUM_REQ;
            if (!w_sel_found && r_pending[PTR_W'(w_idx)]) begin
                w_sel_found = 1'b1;
                w_sel_idx   = PTR_W'(w_idx);
            end
        end
    end

    assign w_sel_onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << w_sel_idx;
    assign w_next_ptr   = (r_grant_idx == PTR_W'(NUM_REQ-1)) ? '0 : r_grant_idx + PTR_W'(1);

`ifdef ARB_TIMEOUT_EN
    logic [TIMEOUT_W-1:0] r_timeout_cnt;
    logic                 r_timeout_err;
    assign timeout_err_out = r_timeout_err;
`else
    logic w_unused_cfg;
    assign w_unused_cfg    = ^{TIMEOUT_W'(TIMEOUT_CYCLES)};
    assign timeout_err_out = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= A_IDLE;
            r_pending   <= '0;
            r_grant     <= '0;
            r_grant_idx <= '0;
            r_rr_ptr    <= '0;
            r_req_pulse <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            r_timeout_cnt <= '0;
            r_timeout_err <= 1'b0;
`endif
        end else begin
            r_pending   <= w_pending_next;
            r_req_pulse <= 1'b0;
            case (r_state)
                A_IDLE: begin
                    if (w_sel_found) begin
                        r_grant     <= w_sel_onehot;
                        r_grant_idx <= w_sel_idx;
                        r_state     <= A_ISSUE;
                    end
                end
                A_ISSUE: begin
                    if (w_gen_ready) begin
                        r_req_pulse <= 1'b1;
                        r_state     <= A_AWAIT;
`ifdef ARB_TIMEOUT_EN
                        r_timeout_cnt <= '0;
`endif
                    end
                end
                A_AWAIT: begin
                    if (hash_byte_pulse) begin
                        r_rr_ptr <= w_next_ptr;
                        r_grant  <= '0;
                        r_state  <= A_IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    // Grant is kept so the same requester is re-issued after the generator went silent.
                    else if (r_timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES-1)) begin
                        r_timeout_err <= 1'b1;
                        r_state       <= A_ISSUE;
                    end else begin
                        r_timeout_cnt <= r_timeout_cnt + TIMEOUT_W'(1);
                    end
`endif
                end
                default: r_state <= A_IDLE;
            endcase
        end
    end

    assign request_byte_pulse_out = r_req_pulse;
    assign hash_byte_out          = hash_byte;
    assign grant_out              = r_grant;
    assign pending_out            = r_pending;
    assign busy_out               = (r_state != A_IDLE);

endmodule

// File: tb/tb_hash_request_arbiter.sv
// Directed bench for hash_request_arbiter (NUM_REQ=2, TIMEOUT_CYCLES=4); timeout case built only with ARB_TIMEOUT_EN.
module tb_hash_request_arbiter;
    import hash_request_arbiter_pkg::*;

    logic                  clk = 1'b0;
    logic                  rst;
    logic [1:0]            req_pulse_in;
    hash_generator_state_t gen_state;
    logic                  request_byte_pulse_out;
    logic [7:0]            hash_byte;
    logic                  hash_byte_pulse;
    logic [7:0]            hash_byte_out;
    logic [1:0]            hash_byte_pulse_out;
    logic [1:0]            grant_out;
    logic [1:0]            pending_out;
    logic                  busy_out;
    logic                  timeout_err_out;

    int checks   = 0;
    int failures = 0;
    int req_cnt  = 0;

    hash_request_arbiter #(
        .NUM_REQ        (2),
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_W      (8)
    ) dut (
        .clk                    (clk),
        .rst                    (rst),
        .req_pulse_in           (req_pulse_in),
        .hash_generator_state   (gen_state),
        .request_byte_pulse_out (request_byte_pulse_out),
        .hash_byte              (hash_byte),
        .hash_byte_pulse        (hash_byte_pulse),
        .hash_byte_out          (hash_byte_out),
        .hash_byte_pulse_out    (hash_byte_pulse_out),
        .grant_out              (grant_out),
        .pending_out            (pending_out),
        .busy_out               (busy_out),
        .timeout_err_out        (timeout_err_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (request_byte_pulse_out === 1'b1) req_cnt <= req_cnt + 1;
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst             = 1'b1;
        req_pulse_in    = 2'b00;
        hash_byte_pulse = 1'b0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Waits for the request pulse, checks the grant, then completes the transaction one cycle later.
    task automatic serve(input string tag, input logic [1:0] exp_grant, input logic [7:0] b, input logic repulse);
        int n;
        n = 0;
        while (request_byte_pulse_out !== 1'b1 && n < 30) begin
            tick();
            n++;
        end
        check_eq({tag, "_req_seen"}, 32'(n < 30), 32'd1);
        check_eq({tag, "_grant"}, grant_out, exp_grant);
        tick();
        check_eq({tag, "_req_one_cycle"}, request_byte_pulse_out, 1'b0);
        hash_byte       = b;
        hash_byte_pulse = 1'b1;
        if (repulse) req_pulse_in = 2'b11;
        #1;
        check_eq({tag, "_route"}, hash_byte_pulse_out, exp_grant);
        check_eq({tag, "_bcast"}, hash_byte_out, b);
        $display("txn %s grant=%b byte=%h", tag, exp_grant, b);
        tick();
        hash_byte_pulse = 1'b0;
        req_pulse_in    = 2'b00;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        logic seen;
        gen_state = H_READY;
        hash_byte = 8'h3C;
        do_reset();

        // Reset state
        #1;
        check_eq("rst_grant", grant_out, 2'b00);
        check_eq("rst_pending", pending_out, 2'b00);
        check_eq("rst_busy", busy_out, 1'b0);
        check_eq("rst_req", request_byte_pulse_out, 1'b0);
        check_eq("rst_route", hash_byte_pulse_out, 2'b00);
        check_eq("rst_terr", timeout_err_out, 1'b0);
        check_eq("rst_bcast", hash_byte_out, 8'h3C);

        // 1. Single requester, exact latency
        req_pulse_in = 2'b01;               // t0
        tick(); req_pulse_in = 2'b00; #1;   // t1
        check_eq("t1_pending", pending_out, 2'b01);
        check_eq("t1_busy", busy_out, 1'b0);
        tick();                             // t2
        check_eq("t2_grant", grant_out, 2'b01);
        check_eq("t2_busy", busy_out, 1'b1);
        check_eq("t2_req", request_byte_pulse_out, 1'b0);
        tick();                             // t3
        check_eq("t3_req", request_byte_pulse_out, 1'b1);
        tick();                             // t4
        check_eq("t4_req", request_byte_pulse_out, 1'b0);
        check_eq("t4_pending", pending_out, 2'b01);
        tick();                             // t5
        hash_byte = 8'hA5; hash_byte_pulse = 1'b1; #1;
        check_eq("t5_route", hash_byte_pulse_out, 2'b01);
        check_eq("t5_bcast", hash_byte_out, 8'hA5);
        $display("txn single grant=01 byte=a5");
        tick(); hash_byte_pulse = 1'b0; #1; // t6
        check_eq("t6_pending", pending_out, 2'b00);
        check_eq("t6_grant", grant_out, 2'b00);
        check_eq("t6_busy", busy_out, 1'b0);
        check_eq("t6_route", hash_byte_pulse_out, 2'b00);

        // 2. Simultaneous requests, H_GROUND also counts as ready
        do_reset();
        gen_state = H_GROUND;
        c0 = req_cnt;
        req_pulse_in = 2'b11;
        tick(); req_pulse_in = 2'b00; #1;
        check_eq("sim_pending", pending_out, 2'b11);
        serve("sim0", 2'b01, 8'h11, 1'b0);
        serve("sim1", 2'b10, 8'h22, 1'b0);
        tick();
        check_eq("sim_req_count", 32'(req_cnt - c0), 32'd2);
        check_eq("sim_pending_end", pending_out, 2'b00);

        // 3. Fairness with immediate re-requests
        do_reset();
        gen_state = H_READY;
        req_pulse_in = 2'b11;
        tick(); req_pulse_in = 2'b00;
        serve("rr0", 2'b01, 8'h31, 1'b1);
        serve("rr1", 2'b10, 8'h32, 1'b1);
        serve("rr2", 2'b01, 8'h33, 1'b1);
        serve("rr3", 2'b10, 8'h34, 1'b0);

        // 4. Generator busy while in A_ISSUE, stray hash pulse ignored
        do_reset();
        gen_state = H_HASHING;
        req_pulse_in = 2'b01;
        tick(); req_pulse_in = 2'b00;
        tick();
        check_eq("busy_issue", busy_out, 1'b1);
        check_eq("busy_grant", grant_out, 2'b01);
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            gen_state = (i % 2 == 1) ? H_OUTPUT : H_HASHING;
            if (i == 4) begin
                hash_byte_pulse = 1'b1; #1;
                check_eq("busy_stray_route", hash_byte_pulse_out, 2'b00);
            end
            tick();
            hash_byte_pulse = 1'b0;
            if (request_byte_pulse_out !== 1'b0) seen = 1'b1;
        end
        check_eq("busy_no_req", seen, 1'b0);
        check_eq("busy_pending", pending_out, 2'b01);
        gen_state = H_READY;
        tick();
        check_eq("busy_req_after_ready", request_byte_pulse_out, 1'b1);
        tick();
        check_eq("busy_req_one_cycle", request_byte_pulse_out, 1'b0);
        hash_byte_pulse = 1'b1; #1;
        check_eq("busy_route", hash_byte_pulse_out, 2'b01);
        tick(); hash_byte_pulse = 1'b0;

        // 5. Reset in A_AWAIT, late hash pulse ignored
        do_reset();
        req_pulse_in = 2'b01;
        tick(); req_pulse_in = 2'b00;
        tick(); tick(); tick();
        check_eq("rstw_busy_before", busy_out, 1'b1);
        rst = 1'b1; hash_byte = 8'h5A;
        tick();
        check_eq("rstw_grant", grant_out, 2'b00);
        check_eq("rstw_busy", busy_out, 1'b0);
        check_eq("rstw_pending", pending_out, 2'b00);
        check_eq("rstw_bcast", hash_byte_out, 8'h5A);
        rst = 1'b0;
        tick();
        hash_byte_pulse = 1'b1; #1;
        check_eq("rstw_late_route", hash_byte_pulse_out, 2'b00);
        tick(); hash_byte_pulse = 1'b0; #1;
        check_eq("rstw_idle_busy", busy_out, 1'b0);
        check_eq("rstw_idle_req", request_byte_pulse_out, 1'b0);

        // 6. Timeout behaviour
        do_reset();
        c0 = req_cnt;
        req_pulse_in = 2'b01;
        tick(); req_pulse_in = 2'b00;
        tick(); tick();
        check_eq("to_first_req", request_byte_pulse_out, 1'b1);
`ifdef ARB_TIMEOUT_EN
        for (int i = 0; i < 4; i++) begin
            tick();
            check_eq("to_no_req", request_byte_pulse_out, 1'b0);
            if (i == 2) check_eq("to_err_early", timeout_err_out, 1'b0);
        end
        check_eq("to_err_set", timeout_err_out, 1'b1);
        check_eq("to_grant_kept", grant_out, 2'b01);
        tick();
        check_eq("to_second_req", request_byte_pulse_out, 1'b1);
        tick();
        hash_byte_pulse = 1'b1; #1;
        check_eq("to_route", hash_byte_pulse_out, 2'b01);
        tick(); hash_byte_pulse = 1'b0; #1;
        check_eq("to_err_sticky", timeout_err_out, 1'b1);
        do_reset(); #1;
        check_eq("to_err_cleared", timeout_err_out, 1'b0);
`else
        for (int i = 0; i < 20; i++) tick();
        check_eq("noto_req_count", 32'(req_cnt - c0), 32'd1);
        check_eq("noto_busy", busy_out, 1'b1);
        check_eq("noto_err", timeout_err_out, 1'b0);
        hash_byte_pulse = 1'b1; #1;
        check_eq("noto_route", hash_byte_pulse_out, 2'b01);
        tick(); hash_byte_pulse = 1'b0;
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
